// File: rtl/multicycle_alu_pkg.sv
// Shared definitions for the EX-stage ALU: op codes (also used by the ALU
// control decoder) and the sequencing state encoding.
package multicycle_alu_pkg;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_MUL = 3'b011;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/multicycle_alu_if.sv
// EX-stage request/result bundle between the pipeline (master) and the ALU (slave).
interface multicycle_alu_if #(
   parameter int DATA_W = 32
);
   logic              start_i;
   logic [2:0]        ALUCtrl_i;
   logic [DATA_W-1:0] data1_i;
   logic [DATA_W-1:0] data2_i;
   logic [DATA_W-1:0] data_o;
   logic              zero_o;
   logic              valid_o;
   logic              stall_o;

   modport master (
      output start_i, ALUCtrl_i, data1_i, data2_i,
      input  data_o, zero_o, valid_o, stall_o
   );

   modport slave (
      input  start_i, ALUCtrl_i, data1_i, data2_i,
      output data_o, zero_o, valid_o, stall_o
   );
endinterface

// File: rtl/multicycle_alu_mul_shift_add.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, DATA_W cycles,
// keeps only the low DATA_W bits of the product.
module multicycle_alu_mul_shift_add #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   output logic              done,
   output logic [DATA_W-1:0] product
);

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

   logic [DATA_W-1:0] multiplicand_reg;
   logic [DATA_W-1:0] multiplier_reg;
   logic [DATA_W-1:0] acc_reg;
   logic [CNT_W-1:0]  count_reg;
   logic              busy_reg;
   logic [DATA_W-1:0] addend;
   logic [DATA_W-1:0] acc_next;

   // The partial product is the multiplicand gated by the current multiplier LSB.
   genvar gi;
   generate
      for (gi = 0; gi < DATA_W; gi++) begin : g_addend
         assign addend[gi] = multiplicand_reg[gi] & multiplier_reg[0];
      end
   endgenerate

   assign acc_next = acc_reg + addend;
   assign done     = busy_reg && (count_reg == LAST_CNT);
   // Final accumulator value is presented during the last iteration so the
   // caller can register it on the same edge.
   assign product  = acc_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         multiplicand_reg <= '0;
         multiplier_reg   <= '0;
         acc_reg          <= '0;
         count_reg        <= '0;
         busy_reg         <= 1'b0;
      end else if (start) begin
         multiplicand_reg <= op_a;
         multiplier_reg   <= op_b;
         acc_reg          <= '0;
         count_reg        <= '0;
         busy_reg         <= 1'b1;
      end else if (busy_reg) begin
         acc_reg          <= acc_next;
         multiplicand_reg <= multiplicand_reg << 1;
         multiplier_reg   <= multiplier_reg >> 1;
         count_reg        <= count_reg + 1'b1;
         if (done) begin
            busy_reg <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/multicycle_alu.sv
// EX-stage execution unit: single-cycle ADD/SUB/AND/OR, multi-cycle MUL with
// a pipeline stall request while the multiply is in flight.
module multicycle_alu
   import multicycle_alu_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   multicycle_alu_if.slave alu
);

   state_t            state_reg;
   state_t            state_next;
   logic [DATA_W-1:0] data_reg;
   logic              valid_reg;
   logic [DATA_W-1:0] single_result;
   logic              mul_start;
   logic              alu_load;
   logic              stall_comb;
   logic              mul_done;
   logic [DATA_W-1:0] mul_product;

   multicycle_alu_mul_shift_add #(
      .DATA_W (DATA_W)
   ) u_mul (
      .clk     (clk_i),
      .rst_n   (rst_i),
      .start   (mul_start),
      .op_a    (alu.data1_i),
      .op_b    (alu.data2_i),
      .done    (mul_done),
      .product (mul_product)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (alu.start_i && (alu.ALUCtrl_i == ALU_MUL)) state_next = ST_MUL;
         ST_MUL:  if (mul_done) state_next = ST_DONE;
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // Requests are only honoured in IDLE; the hazard unit holds them otherwise.
   always_comb begin
      mul_start  = 1'b0;
      alu_load   = 1'b0;
      stall_comb = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (alu.start_i) begin
               if (alu.ALUCtrl_i == ALU_MUL) begin
                  mul_start  = 1'b1;
                  stall_comb = 1'b1;
               end else begin
                  alu_load = 1'b1;
               end
            end
         end
         ST_MUL:  stall_comb = 1'b1;
         default: ;
      endcase
   end

   // Undefined codes deliver zero rather than a stale value.
   always_comb begin
      single_result = '0;
      case (alu.ALUCtrl_i)
         ALU_ADD: single_result = alu.data1_i + alu.data2_i;
         ALU_SUB: single_result = alu.data1_i - alu.data2_i;
         ALU_AND: single_result = alu.data1_i & alu.data2_i;
         ALU_OR:  single_result = alu.data1_i | alu.data2_i;
         default: single_result = '0;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         data_reg  <= '0;
         valid_reg <= 1'b0;
      end else begin
         valid_reg <= 1'b0;
         if (alu_load) begin
            data_reg  <= single_result;
            valid_reg <= 1'b1;
         end else if (mul_done) begin
            data_reg  <= mul_product;
            valid_reg <= 1'b1;
         end
      end
   end

   assign alu.data_o  = data_reg;
   assign alu.zero_o  = (data_reg == '0);
   assign alu.valid_o = valid_reg;
   // Gated by reset so the freeze request drops immediately on assertion.
   assign alu.stall_o = stall_comb && rst_i;

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed bench for multicycle_alu: single-cycle ops, multiply latency/stall,
// mid-multiply reset and undefined op codes.
module tb_multicycle_alu;

   localparam int DATA_W = 32;

   logic clk_i = 1'b0;
   logic rst_i = 1'b0;
   int   tests  = 0;
   int   failed = 0;

   multicycle_alu_if #(.DATA_W(DATA_W)) alu_bus ();

   multicycle_alu #(.DATA_W(DATA_W)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .alu   (alu_bus)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input logic st, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      alu_bus.start_i   = st;
      alu_bus.ALUCtrl_i = op;
      alu_bus.data1_i   = a;
      alu_bus.data2_i   = b;
   endtask

   task automatic do_mul(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
      int stall_cnt;
      int valid_in_stall;
      stall_cnt      = 0;
      valid_in_stall = 0;
      drive(1'b1, 3'b011, a, b);
      #1;
      chk({tag, "_stall_t0"}, {31'd0, alu_bus.stall_o}, 32'd1);
      if (alu_bus.stall_o) stall_cnt++;
      for (int i = 0; i < 40; i++) begin
         step();
         alu_bus.start_i = 1'b0;
         if (!alu_bus.stall_o) break;
         stall_cnt++;
         if (alu_bus.valid_o) valid_in_stall++;
      end
      chk({tag, "_stall_cycles"}, stall_cnt, 32'd33);
      chk({tag, "_valid_in_stall"}, valid_in_stall, 32'd0);
      chk({tag, "_valid"}, {31'd0, alu_bus.valid_o}, 32'd1);
      chk({tag, "_data"}, alu_bus.data_o, exp);
      chk({tag, "_zero"}, {31'd0, alu_bus.zero_o}, {31'd0, (exp == 32'd0)});
      $display("[TB] MUL %h * %h -> %h (stall %0d cycles)", a, b, alu_bus.data_o, stall_cnt);
      step();
      chk({tag, "_valid_drop"}, {31'd0, alu_bus.valid_o}, 32'd0);
   endtask

   initial begin
      drive(1'b0, 3'b010, 32'd0, 32'd0);
      #3;
      chk("rst_data", alu_bus.data_o, 32'd0);
      chk("rst_valid", {31'd0, alu_bus.valid_o}, 32'd0);
      chk("rst_stall", {31'd0, alu_bus.stall_o}, 32'd0);
      chk("rst_zero", {31'd0, alu_bus.zero_o}, 32'd1);
      step();
      step();
      rst_i = 1'b1;
      step();

      // ADD wraps into the sign bit, one-cycle latency
      drive(1'b1, 3'b010, 32'h7FFF_FFFF, 32'h0000_0001);
      #1;
      chk("add_stall_t0", {31'd0, alu_bus.stall_o}, 32'd0);
      step();
      alu_bus.start_i = 1'b0;
      chk("add_data", alu_bus.data_o, 32'h8000_0000);
      chk("add_valid", {31'd0, alu_bus.valid_o}, 32'd1);
      chk("add_zero", {31'd0, alu_bus.zero_o}, 32'd0);
      chk("add_stall", {31'd0, alu_bus.stall_o}, 32'd0);
      $display("[TB] ADD 7fffffff + 00000001 -> %h", alu_bus.data_o);
      step();
      chk("add_valid_drop", {31'd0, alu_bus.valid_o}, 32'd0);

      // SUB then OR back to back
      drive(1'b1, 3'b110, 32'd5, 32'd5);
      step();
      chk("sub_data", alu_bus.data_o, 32'd0);
      chk("sub_zero", {31'd0, alu_bus.zero_o}, 32'd1);
      chk("sub_valid", {31'd0, alu_bus.valid_o}, 32'd1);
      $display("[TB] SUB 5 - 5 -> %h", alu_bus.data_o);
      drive(1'b1, 3'b001, 32'hF0F0_0000, 32'h0000_0F0F);
      step();
      alu_bus.start_i = 1'b0;
      chk("or_data", alu_bus.data_o, 32'hF0F0_0F0F);
      chk("or_valid", {31'd0, alu_bus.valid_o}, 32'd1);
      chk("or_zero", {31'd0, alu_bus.zero_o}, 32'd0);
      $display("[TB] OR f0f00000 | 00000f0f -> %h", alu_bus.data_o);
      step();
      chk("or_valid_drop", {31'd0, alu_bus.valid_o}, 32'd0);

      // AND
      drive(1'b1, 3'b000, 32'hFF00_FF00, 32'h0FF0_0FF0);
      step();
      alu_bus.start_i = 1'b0;
      chk("and_data", alu_bus.data_o, 32'h0F00_0F00);
      $display("[TB] AND ff00ff00 & 0ff00ff0 -> %h", alu_bus.data_o);
      step();

      do_mul("mul_a", 32'h0000_1234, 32'h0000_5678, 32'h0626_0060);
      do_mul("mul_zero", 32'h0000_0000, 32'h0000_1234, 32'h0000_0000);
      do_mul("mul_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);

      // Mid-multiply: ADD request ignored, then asynchronous reset
      drive(1'b1, 3'b011, 32'd3, 32'd4);
      step();
      alu_bus.start_i = 1'b0;
      for (int c = 1; c < 20; c++) begin
         if (c == 10) drive(1'b1, 3'b010, 32'd2, 32'd3);
         if (c == 11) alu_bus.start_i = 1'b0;
         step();
         if (c == 10) begin
            chk("mid_add_ignored_valid", {31'd0, alu_bus.valid_o}, 32'd0);
            chk("mid_add_ignored_data", alu_bus.data_o, 32'd1);
            chk("mid_stall", {31'd0, alu_bus.stall_o}, 32'd1);
         end
      end
      #2;
      rst_i = 1'b0;
      #1;
      chk("arst_stall", {31'd0, alu_bus.stall_o}, 32'd0);
      chk("arst_data", alu_bus.data_o, 32'd0);
      chk("arst_valid", {31'd0, alu_bus.valid_o}, 32'd0);
      chk("arst_zero", {31'd0, alu_bus.zero_o}, 32'd1);
      $display("[TB] RESET mid-multiply -> data %h stall %b", alu_bus.data_o, alu_bus.stall_o);
      step();
      rst_i = 1'b1;
      step();
      chk("post_rst_valid", {31'd0, alu_bus.valid_o}, 32'd0);
      drive(1'b1, 3'b010, 32'd2, 32'd3);
      step();
      alu_bus.start_i = 1'b0;
      chk("post_rst_add_data", alu_bus.data_o, 32'd5);
      chk("post_rst_add_valid", {31'd0, alu_bus.valid_o}, 32'd1);
      $display("[TB] ADD 2 + 3 after reset -> %h", alu_bus.data_o);
      step();

      // Undefined code, then an ADD accepted right behind it
      drive(1'b1, 3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      #1;
      chk("undef_stall", {31'd0, alu_bus.stall_o}, 32'd0);
      step();
      chk("undef_data", alu_bus.data_o, 32'd0);
      chk("undef_valid", {31'd0, alu_bus.valid_o}, 32'd1);
      $display("[TB] OP 111 -> %h", alu_bus.data_o);
      drive(1'b1, 3'b010, 32'd1, 32'd1);
      step();
      alu_bus.start_i = 1'b0;
      chk("undef_then_add_data", alu_bus.data_o, 32'd2);
      chk("undef_then_add_valid", {31'd0, alu_bus.valid_o}, 32'd1);
      $display("[TB] ADD 1 + 1 after OP 111 -> %h", alu_bus.data_o);
      step();
      chk("final_valid_drop", {31'd0, alu_bus.valid_o}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/multicycle_alu.md
Name: multicycle_alu

Overview:
- EX-stage execution unit; directly consumes the 3-bit ALU control code from the ALU control decoder and the two operands from the forwarding muxes.
- ADD/SUB/AND/OR complete in one registered cycle. MUL uses an iterative shift-add datapath over DATA_W cycles.
- Asserts stall_o so the hazard unit freezes PC, IF/ID and ID/EX while a multiply is in flight.

Parameters:
- DATA_W, 32, operand/result width; MUL iteration count equals DATA_W.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- start_i  input  1  an EX-stage instruction is presented this cycle.
- ALUCtrl_i  input  3  op code: 010 ADD, 110 SUB, 000 AND, 001 OR, 011 MUL; all other codes are undefined.
- data1_i  input  DATA_W  operand A.
- data2_i  input  DATA_W  operand B.
- data_o  output  DATA_W  registered result.
- zero_o  output  1  high when data_o is all zeros.
- valid_o  output  1  one-cycle pulse; data_o is valid in that cycle.
- stall_o  output  1  pipeline-freeze request.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - state=IDLE; data_o=0; valid_o=0; stall_o=0; count=0; partial product=0.
  - zero_o=1, because it follows data_o.
- States: IDLE, MUL, DONE.
- IDLE with start_i=1 and a non-MUL op:
  - The result is registered at the next edge; valid_o=1 for exactly that one cycle. Latency is 1.
  - The state stays IDLE, so back-to-back ops can be accepted every cycle.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^DATA_W; no overflow flag.
  - AND/OR are bitwise.
- Undefined ALUCtrl_i code: data_o=0 and valid_o=1. The unit must not hang or latch a stale result.
- IDLE with start_i=1 and ALUCtrl_i=011 (acceptance cycle, call it T0):
  - stall_o goes high combinationally in T0.
  - At the T0 edge: data1_i/data2_i are latched into the multiplicand/multiplier registers, acc=0, count=0, state goes to MUL.
- MUL state, one iteration per cycle:
  - If multiplier[0]=1, acc += multiplicand. Then multiplicand <<= 1, multiplier >>= 1, count++.
  - Only the low DATA_W bits are kept, which equals the low word of both signed and unsigned products.
  - When count reaches DATA_W-1, the edge performs the last iteration and moves to DONE.
  - stall_o=1 throughout MUL.
- DONE state, one cycle:
  - data_o=acc; valid_o=1; stall_o=0. Next state is IDLE.
  - For DATA_W=32: accept at T0, valid_o in cycle T0+33, stall_o high from T0 through T0+32 (33 cycles).
- start_i outside IDLE (MUL or DONE): ignored; operands are not sampled. The hazard unit holds the instruction during stall.
- valid_o=0 in every cycle where no result is being delivered. data_o holds its last value between results.
- Reset mid-multiply: return to IDLE immediately, discard the partial product, deassert stall_o; no valid_o pulse.
- Multiplicand or multiplier equal to 0: the unit still runs all DATA_W iterations. Latency is fixed, with no early exit.

Decomposition:
- Shared package: ALU op-code localparams (ALU_ADD=3'b010, ALU_SUB=3'b110, ALU_AND=3'b000, ALU_OR=3'b001, ALU_MUL=3'b011), shared with the ALU control decoder. The state encoding lives there too.
- One natural sub-module: mul_shift_add. It holds the multiplicand/multiplier/acc registers and the counter, with start/done handshake ports.
- The top level holds the FSM, the single-cycle ops and the output register.

Test Plan:
- Reset, then ADD 0x7FFFFFFF + 0x00000001 -> next cycle data_o=0x80000000, valid_o=1 for one cycle, zero_o=0, stall_o never high.
- SUB 5 − 5 followed back-to-back by OR 0xF0F0_0000 | 0x0000_0F0F -> consecutive results 0 (zero_o=1) then 0xF0F0_0F0F, each with valid_o pulses.
- MUL 0x00001234 × 0x00005678 -> stall_o high for exactly 33 cycles from acceptance, then valid_o with data_o=0x06260060; valid_o=0 throughout the stall.
- MUL 0xFFFFFFFF × 0xFFFFFFFF -> data_o=0x00000001. MUL 0 × 0x1234 -> data_o=0, zero_o=1, same 33-cycle stall.
- Start a MUL, toggle start_i with an ADD at cycle 10, assert rst_i=0 at cycle 20 -> ADD ignored; outputs clear and stall_o drops asynchronously. After release, a fresh ADD 2+3 returns 5 in 1 cycle.
- ALUCtrl_i=3'b111 with start_i=1 -> data_o=0, valid_o=1 for one cycle, state stays IDLE.
